// File: rtl/johnson_counter_param_pkg.sv
// -----------------------------------------------------------------------------
// johnson_counter_param_pkg
// Shared helpers for the parametrised Johnson (twisted-ring) counter.
// A package cannot take a module parameter, so every helper works on a code
// zero-extended to JC_MAX_W bits and takes the live register width as an
// argument. Callers size results back down to WIDTH / PW with a cast.
//   jc_encode(width, p)    : phase p -> Johnson code
//   jc_decode(width, code) : Johnson code -> binary phase
//   jc_valid(width, code)  : 1 if code is a legal Johnson state
//   jc_pw(width)           : width of the phase index for a given WIDTH
// -----------------------------------------------------------------------------
package johnson_counter_param_pkg;

    localparam int JC_MAX_W  = 16;
    localparam int JC_MAX_PW = 5;

    typedef logic [JC_MAX_W-1:0] jc_code_t;

    function automatic int jc_pw(input int width);
        return $clog2(2 * width);
    endfunction

    // p <= width : p ones in the LSBs
    // p >  width : (2*width - p) ones in the MSBs, i.e. bits p-width .. width-1
    function automatic jc_code_t jc_encode(input int width, input int p);
        jc_code_t c;
        c = '0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if (i < width) begin
                if (p <= width) c[i] = (i < p);
                else            c[i] = (i >= p - width);
            end
        end
        return c;
    endfunction

    // Codes whose LSB is set (or all-zero) are on the filling half of the
    // cycle, so the phase is the number of ones; otherwise the ring is
    // emptying and the phase counts back down from 2*width.
    function automatic int jc_decode(input int width, input jc_code_t code);
        int pop;
        pop = 0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if (i < width && code[i]) pop++;
        end
        if (code[0] || pop == 0) return pop;
        return 2 * width - pop;
    endfunction

    // A legal Johnson code has at most one boundary between a run of ones
    // and a run of zeros.
    function automatic logic jc_valid(input int width, input jc_code_t code);
        int edges;
        edges = 0;
        for (int i = 0; i < JC_MAX_W - 1; i++) begin
            if (i < width - 1 && code[i] != code[i+1]) edges++;
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// -----------------------------------------------------------------------------
// johnson_phase_decode
// Combinational decoder from a Johnson code to its binary phase, plus a
// legality flag used for upset detection.
// Ports:
//   code  in  WIDTH  Johnson code
//   phase out PW     binary phase index (meaningful only when valid)
//   valid out 1      1 when code is a legal Johnson state
// -----------------------------------------------------------------------------
module johnson_phase_decode
    import johnson_counter_param_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = 3
) (
    input  logic [WIDTH-1:0] code,
    output logic [PW-1:0]    phase,
    output logic             valid
);

    always_comb begin
        phase = PW'(jc_decode(WIDTH, jc_code_t'(code)));
        valid = jc_valid(WIDTH, jc_code_t'(code));
    end

endmodule

// File: rtl/johnson_counter_param.sv
// -----------------------------------------------------------------------------
// johnson_counter_param
// Parametrised bidirectional Johnson counter with enable, synchronous clear,
// phase load, binary phase readout, wrap pulse and illegal-state recovery
// with a sticky error flag.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous reset, active-low
//   en         in  1      count enable, one step per clock
//   dir        in  1      1 = up (shift left), 0 = down (shift right)
//   clr        in  1      synchronous clear to phase 0, also clears err
//   load       in  1      synchronous load of load_phase
//   load_phase in  PW     phase to load, 0..2*WIDTH-1
//   out        out WIDTH  registered Johnson code
//   phase      out PW     binary phase of out (decoded from the register)
//   wrap       out 1      registered one-cycle pulse on sequence wrap
//   err        out 1      registered sticky error flag
// -----------------------------------------------------------------------------
module johnson_counter_param
    import johnson_counter_param_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [PW-1:0]    load_phase,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    localparam int JC_LEN = 2 * WIDTH;

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [PW-1:0]    phase_w;
    logic             code_valid;

    johnson_phase_decode #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_decode (
        .code  (out_q),
        .phase (phase_w),
        .valid (code_valid)
    );

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        err_d  = err_q;
        if (clr) begin
            out_d = '0;
            err_d = 1'b0;
        end else if (load) begin
            // An out-of-range phase leaves the counter where it is and flags it.
            if (int'(load_phase) < JC_LEN) out_d = WIDTH'(jc_encode(WIDTH, int'(load_phase)));
            else                           err_d = 1'b1;
        end else if (!code_valid) begin
            // Recover from an upset even while the counter is idle.
            out_d = '0;
            err_d = 1'b1;
        end else if (en) begin
            if (dir) begin
                out_d  = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
                wrap_d = (phase_w == PW'(JC_LEN - 1));
            end else begin
                out_d  = {~out_q[0], out_q[WIDTH-1:1]};
                wrap_d = (phase_w == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign out   = out_q;
    assign phase = phase_w;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule
